// File: rtl/scrambler_arb_ctrl.sv
// Round-robin controller time-sharing one 4-bit LFSR scrambler between two requesters.
// Optional macro SCR_CTX_SAVE_EN keeps a per-requester LFSR context for continuous keystreams.
module scrambler_arb_ctrl #(
    parameter logic [3:0]  DEFAULT_SEED = 4'h1,
    parameter int unsigned POP_WAIT_MAX = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [3:0] req0_seed,
    input  logic [3:0] req1_seed,
    input  logic [3:0] req0_data,
    input  logic [3:0] req1_data,
    input  logic       req0_reseed,
    input  logic       req1_reseed,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    input  logic       rsp0_ready,
    input  logic       rsp1_ready,
    output logic [3:0] rsp0_data,
    output logic [3:0] rsp1_data,
    output logic       s_EN_seed,
    output logic [3:0] s_seed_value,
    output logic       s_EN_in,
    output logic [3:0] s_in_data,
    output logic       s_EN_out,
    input  logic [3:0] s_out,
    input  logic       s_RDY_out,
    output logic       gnt_id,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, LOAD, POP, RESP} state_t;

    state_t     state, state_nxt;
    logic       last_gnt;
    logic [3:0] seed_q, data_q, pop_cnt;
    logic [3:0] seed_sel;
    logic       grant, win_id, pop_hit, pop_timeout;

`ifdef SCR_CTX_SAVE_EN
    logic [3:0] ctx0, ctx1;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return s[0] ? {1'b1, s[3:2], ~s[1]} : {1'b0, s[3:1]};
    endfunction

    // The saved context stands in for the seed unless the requester asks to reseed.
    always_comb begin
        if (win_id) seed_sel = req1_reseed ? req1_seed : ctx1;
        else        seed_sel = req0_reseed ? req0_seed : ctx0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctx0 <= DEFAULT_SEED;
            ctx1 <= DEFAULT_SEED;
        end else if (pop_hit) begin
            if (gnt_id) ctx1 <= lfsr_next(seed_q);
            else        ctx0 <= lfsr_next(seed_q);
        end
    end
`else
    logic [4:0] unused_cfg;
    assign unused_cfg = {req0_reseed ^ req1_reseed, DEFAULT_SEED};
    assign seed_sel   = win_id ? req1_seed : req0_seed;
`endif

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        win_id      = 1'b0;
        pop_hit     = 1'b0;
        pop_timeout = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                grant      = req0_valid | req1_valid;
                win_id     = (req0_valid & req1_valid) ? ~last_gnt : req1_valid;
                req0_ready = grant & ~win_id;
                req1_ready = grant & win_id;
                if (grant) state_nxt = LOAD;
            end
            LOAD: state_nxt = POP;
            POP: begin
                if (s_RDY_out) begin
                    pop_hit   = 1'b1;
                    state_nxt = RESP;
                end else if (pop_cnt == 4'(POP_WAIT_MAX - 1)) begin
                    pop_timeout = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                if (gnt_id ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_EN_seed    = (state == LOAD);
    assign s_EN_in      = (state == LOAD);
    assign s_seed_value = s_EN_seed ? seed_q : 4'h0;
    assign s_in_data    = s_EN_in ? data_q : 4'h0;
    assign s_EN_out     = pop_hit;
    assign rsp0_valid   = (state == RESP) & ~gnt_id;
    assign rsp1_valid   = (state == RESP) & gnt_id;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            gnt_id    <= 1'b0;
            seed_q    <= 4'h0;
            data_q    <= 4'h0;
            pop_cnt   <= 4'h0;
            rsp0_data <= 4'h0;
            rsp1_data <= 4'h0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                gnt_id   <= win_id;
                last_gnt <= win_id;
                seed_q   <= seed_sel;
                data_q   <= win_id ? req1_data : req0_data;
            end
            if (state == POP && !s_RDY_out) pop_cnt <= pop_cnt + 4'd1;
            else                            pop_cnt <= 4'h0;
            // A timed-out pop returns zero so stale scrambler output never leaks out.
            if (pop_hit || pop_timeout) begin
                if (gnt_id) rsp1_data <= pop_hit ? s_out : 4'h0;
                else        rsp0_data <= pop_hit ? s_out : 4'h0;
            end
            if (pop_timeout) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_scrambler_arb_ctrl.sv
// Self-checking bench for scrambler_arb_ctrl: behavioural scrambler, abstract reference
// model of grants, keystream contexts and the sticky error, plus directed and random traffic.
module tb_scrambler_arb_ctrl;
    localparam int POP_WAIT_MAX = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_seed, req1_seed, req0_data, req1_data;
    logic       req0_reseed, req1_reseed;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [3:0] rsp0_data, rsp1_data;
    logic       s_EN_seed, s_EN_in, s_EN_out, s_RDY_out;
    logic [3:0] s_seed_value, s_in_data, s_out;
    logic       gnt_id, err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    scrambler_arb_ctrl #(.DEFAULT_SEED(4'h1), .POP_WAIT_MAX(POP_WAIT_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_seed(req0_seed), .req1_seed(req1_seed),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_reseed(req0_reseed), .req1_reseed(req1_reseed),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
        .s_EN_seed(s_EN_seed), .s_seed_value(s_seed_value),
        .s_EN_in(s_EN_in), .s_in_data(s_in_data),
        .s_EN_out(s_EN_out), .s_out(s_out), .s_RDY_out(s_RDY_out),
        .gnt_id(gnt_id), .err(err)
    );

    // Galois form of the scrambler step: shift right, fold in 4'h9 when a one falls out.
    function automatic logic [3:0] nextState(input logic [3:0] s);
        logic [3:0] fb;
        fb = s[0] ? 4'h9 : 4'h0;
        return (s >> 1) ^ fb;
    endfunction

    logic [3:0] scr_state = 4'h0, scr_data = 4'h0, seen_seed = 4'h0;
    logic       scr_loaded = 1'b0, stall = 1'b0;
    int         en_out_cnt = 0, pair_err = 0, idle_drive_err = 0;

    assign s_RDY_out = scr_loaded & ~stall;
    assign s_out     = scr_state ^ scr_data;

    // Scrambler stand-in that also watches the enable protocol on every edge.
    always @(posedge CLK) begin
        if (s_EN_seed !== s_EN_in) pair_err++;
        if ((!s_EN_seed && s_seed_value !== 4'h0) || (!s_EN_in && s_in_data !== 4'h0)) idle_drive_err++;
        if (s_EN_out) en_out_cnt++;
        if (s_EN_seed) begin
            scr_state <= s_seed_value;
            seen_seed <= s_seed_value;
        end
        if (s_EN_in) begin
            scr_data   <= s_in_data;
            scr_loaded <= 1'b1;
        end
        if (s_EN_out) begin
            scr_state  <= nextState(scr_state);
            scr_loaded <= 1'b0;
        end
    end

    logic [3:0] ctx_m [2];
    logic       last_m, err_m;

    task automatic resetModel();
        ctx_m[0] = 4'h1;
        ctx_m[1] = 4'h1;
        last_m   = 1'b1;
        err_m    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [3:0] s0, input logic [3:0] d0, input logic r0,
                                 input logic v1, input logic [3:0] s1, input logic [3:0] d1, input logic r1);
        req0_valid = v0; req0_seed = s0; req0_data = d0; req0_reseed = r0;
        req1_valid = v1; req1_seed = s1; req1_data = d1; req1_reseed = r1;
    endtask

    // Serve one transaction end to end; the accept cycle counts as cycle 1, so a
    // response in cycle 4 is three falling edges after the grant is seen.
    task automatic serveOne(input logic stall_en, input int hold, output logic [3:0] got);
        logic       exp_w, rsp_v, rs;
        logic [3:0] seed_in, seed_used, data_used, exp_rsp;
        int         cyc, pulses0, exp_lat;
        stall = stall_en;
        got   = 4'h0;
        #1;
        cyc = 0;
        while (!(req0_ready || req1_ready) && cyc < 20) begin
            @(negedge CLK); #1; cyc++;
        end
        checkOutput("grant_seen", 32'(req0_ready || req1_ready), 32'd1);
        if (!(req0_ready || req1_ready)) return;
        exp_w = (req0_valid && req1_valid) ? ~last_m : req1_valid;
        checkOutput("winner", 32'(req1_ready), 32'(exp_w));
        checkOutput("loser_ready", 32'(exp_w ? req0_ready : req1_ready), 32'd0);
        seed_in   = exp_w ? req1_seed : req0_seed;
        data_used = exp_w ? req1_data : req0_data;
        rs        = exp_w ? req1_reseed : req0_reseed;
`ifdef SCR_CTX_SAVE_EN
        seed_used = rs ? seed_in : ctx_m[exp_w];
`else
        seed_used = seed_in;
        rs        = 1'b0;
`endif
        exp_rsp = stall_en ? 4'h0 : (seed_used ^ data_used);
        if (!stall_en) ctx_m[exp_w] = nextState(seed_used);
        last_m  = exp_w;
        err_m   = err_m | stall_en;
        exp_lat = stall_en ? 2 + POP_WAIT_MAX : 3;
        pulses0 = en_out_cnt;
        cyc   = 0;
        rsp_v = 1'b0;
        while (!rsp_v && cyc < 30) begin
            @(negedge CLK); #1; cyc++;
            if (cyc == 1) begin
                if (exp_w) req1_valid = 1'b0; else req0_valid = 1'b0;
                checkOutput("load_enables", 32'({s_EN_seed, s_EN_in}), 32'd3);
                checkOutput("load_seed", 32'(s_seed_value), 32'(seed_used));
                checkOutput("load_data", 32'(s_in_data), 32'(data_used));
            end
            rsp_v = exp_w ? rsp1_valid : rsp0_valid;
        end
        checkOutput("rsp_latency", 32'(cyc), 32'(exp_lat));
        got = exp_w ? rsp1_data : rsp0_data;
        checkOutput("rsp_data", 32'(got), 32'(exp_rsp));
        checkOutput("gnt_id", 32'(gnt_id), 32'(exp_w));
        checkOutput("other_rsp_valid", 32'(exp_w ? rsp0_valid : rsp1_valid), 32'd0);
        checkOutput("err", 32'(err), 32'(err_m));
        checkOutput("pop_pulses", 32'(en_out_cnt - pulses0), stall_en ? 32'd0 : 32'd1);
        stall = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK); #1;
            checkOutput("held_data", 32'(exp_w ? rsp1_data : rsp0_data), 32'(exp_rsp));
            checkOutput("held_valid", 32'(exp_w ? rsp1_valid : rsp0_valid), 32'd1);
            checkOutput("waiting_ready", 32'(req0_ready | req1_ready), 32'd0);
        end
        if (exp_w) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        #1;
        checkOutput("no_same_cycle_grant", 32'(req0_ready | req1_ready), 32'd0);
        @(negedge CLK); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        checkOutput("rsp_dropped", 32'(exp_w ? rsp1_valid : rsp0_valid), 32'd0);
        checkOutput("next_grant", 32'(exp_w ? req0_ready : req1_ready),
                    32'(exp_w ? req0_valid : req1_valid));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] got;
        applyStimulus(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        RST = 1'b1;
        resetModel();
        @(negedge CLK); #1;
        checkOutput("reset_outputs", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
                    s_EN_seed, s_seed_value, s_EN_in, s_in_data, s_EN_out, gnt_id, err}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Tie straight after reset: req0 first, then req1.
        applyStimulus(1, 4'h1, 4'h3, 1, 1, 4'h6, 4'h0, 1);
        serveOne(0, 0, got);
        checkOutput("tie_rsp0", 32'(got), 32'h2);
        serveOne(0, 0, got);
        checkOutput("tie_rsp1", 32'(got), 32'h6);

        // Next tie goes back to req0; then interleaved reseed / context traffic.
        applyStimulus(1, 4'h9, 4'h5, 1, 1, 4'h2, 4'h0, 1);
        serveOne(0, 0, got);
        checkOutput("single_rsp0", 32'(got), 32'hC);
        serveOne(0, 0, got);
        checkOutput("ctx_rsp1", 32'(got), 32'h2);
        applyStimulus(1, 4'h7, 4'h0, 0, 0, 4'h0, 4'h0, 0);
        serveOne(0, 0, got);
`ifdef SCR_CTX_SAVE_EN
        checkOutput("ctx_rsp0", 32'(got), 32'hD);
`endif

        // Backpressure: req0 held in RESP for 10 cycles while req1 waits.
        applyStimulus(0, 4'h0, 4'h0, 0, 1, 4'h4, 4'hA, 1);
        serveOne(0, 0, got);
        applyStimulus(1, 4'hB, 4'h6, 1, 1, 4'h3, 4'h9, 1);
        serveOne(0, 10, got);
        serveOne(0, 0, got);

        // Timeout, then good traffic keeps err sticky.
        applyStimulus(1, 4'h5, 4'hF, 1, 0, 4'h0, 4'h0, 0);
        serveOne(1, 0, got);
        applyStimulus(0, 4'h0, 4'h0, 0, 1, 4'h8, 4'h1, 1);
        serveOne(0, 2, got);
        applyStimulus(1, 4'hE, 4'h2, 0, 0, 4'h0, 4'h0, 0);
        serveOne(0, 0, got);

        for (int n = 0; n < 24; n++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1; req0_seed = 4'($urandom); req0_data = 4'($urandom);
                req0_reseed = 1'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1; req1_seed = 4'($urandom); req1_data = 4'($urandom);
                req1_reseed = 1'($urandom);
            end
            if (!req0_valid && !req1_valid) begin
                req1_valid = 1'b1; req1_seed = 4'($urandom); req1_data = 4'($urandom);
                req1_reseed = 1'($urandom);
            end
            serveOne($urandom_range(0, 5) == 0, int'($urandom_range(0, 3)), got);
        end
        for (int n = 0; n < 2; n++) begin
            if (req0_valid || req1_valid) serveOne(0, 0, got);
        end

        // Reset while parked in POP: everything clears asynchronously.
        applyStimulus(1, 4'h6, 4'h9, 1, 0, 4'h0, 4'h0, 0);
        stall = 1'b1;
        #1;
        @(negedge CLK); #1;
        @(negedge CLK); #2;
        RST = 1'b1;
        req0_valid = 1'b0;
        #1;
        checkOutput("reset_in_pop", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
                    s_EN_seed, s_seed_value, s_EN_in, s_in_data, s_EN_out, gnt_id, err}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        stall = 1'b0;
        resetModel();
        applyStimulus(1, 4'hA, 4'h0, 0, 1, 4'h5, 4'h3, 0);
        serveOne(0, 0, got);
`ifdef SCR_CTX_SAVE_EN
        checkOutput("post_reset_ctx", 32'(got), 32'h1);
`endif
        serveOne(0, 0, got);

        checkOutput("enable_pairing", 32'(pair_err), 32'd0);
        checkOutput("idle_bus_zero", 32'(idle_drive_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
